// File: rtl/i2c_target_responder_if.sv
// Bus-side signal bundle for the I2C target responder: pins, status pulses and
// the read/write byte handshake.
interface i2c_target_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       addr_match;
    logic       rw;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;
    logic       stop_det;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, addr_match, rw, rx_data, rx_valid, tx_req, busy, stop_det
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, addr_match, rw, rx_data, rx_valid, tx_req, busy, stop_det
    );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target engine: synchronises SCL/SDA, detects START/STOP, ACKs OWN_ADDR,
// receives write bytes and serves read bytes. Only ever pulls SDA low.
module i2c_target_responder #(
    parameter logic [6:0]  OWN_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    i2c_target_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   byte_done_q, byte_done_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   rw_q, rw_d;
    logic                   busy_q, busy_d;
    logic                   addr_match_q, addr_match_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_req_q, tx_req_d;
    logic                   stop_det_q, stop_det_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_evt = scl_s & sda_prev_q & ~sda_s;
    assign stop_evt  = scl_s & ~sda_prev_q & sda_s;

    // Synchronisers reset to the idle-high bus level so release of reset
    // never looks like a STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            byte_done_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_req_q     <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            byte_done_q  <= byte_done_d;
            sda_oe_q     <= sda_oe_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
            rx_valid_q   <= rx_valid_d;
            tx_req_q     <= tx_req_d;
            stop_det_q   <= stop_det_d;
        end
    end

    always_comb begin
        scl_sync_d   = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
        sda_sync_d   = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
        scl_prev_d   = scl_s;
        sda_prev_d   = sda_s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        byte_done_d  = byte_done_q;
        sda_oe_d     = sda_oe_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        addr_match_d = 1'b0;
        rx_valid_d   = 1'b0;
        tx_req_d     = 1'b0;
        stop_det_d   = 1'b0;

        if (start_evt) begin
            state_d     = ADDR;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
            byte_done_d = 1'b0;
        end else if (stop_evt) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_det_d  = 1'b1;
            byte_done_d = 1'b0;
        end else begin
            // byte_done marks "8th rise seen, act on the coming fall".
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shift_q[6:0] == OWN_ADDR) begin
                                addr_match_d = 1'b1;
                                rw_d         = sda_s;
                                byte_done_d  = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        state_d     = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) begin
                        tx_req_d = rw_q;
                    end else if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            shift_d  = bus.tx_data;
                            sda_oe_d = ~bus.tx_data[7];
                            state_d  = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d   = {shift_q[6:0], sda_s};
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        state_d     = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            cnt_d    = cnt_q + 3'd1;
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_d    = 1'b1;
                            byte_done_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        cnt_d       = '0;
                        shift_d     = bus.tx_data;
                        sda_oe_d    = ~bus.tx_data[7];
                        state_d     = RD_DATA;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.addr_match = addr_match_q;
    assign bus.rw         = rw_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req_q;
    assign bus.busy       = busy_q;
    assign bus.stop_det   = stop_det_q;
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-level I2C master plus a transaction-level
// model of what the target must answer, checked against the DUT.
`timescale 1ns/1ps
module tb_i2c_target_responder;
    localparam logic [6:0] OWN = 7'h50;
    localparam time        Q   = 2500;   // quarter of a 10 us SCL period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #50 clk = ~clk;

    i2c_target_responder_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target_responder #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Observed event counts
    int   n_am = 0, n_rxv = 0, n_txr = 0, n_stop = 0;
    logic last_rw = 1'b0;

    // Model state
    int         e_am = 0, e_rxv = 0, e_txr = 0, e_stop = 0;
    logic [7:0] e_rx = 8'h00;
    logic       e_rw = 1'b0;
    logic       e_addressed = 1'b0;
    logic       oe_allowed = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: pulse counting, pulse width, SDA discipline, tx_data service.
    initial begin
        logic p_am, p_rxv, p_txr, p_stop, p_oe;
        p_am = 0; p_rxv = 0; p_txr = 0; p_stop = 0; p_oe = 0;
        bus.tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.addr_match) begin
                    n_am++;
                    last_rw = bus.rw;
                    check("addr_match_width", 32'(p_am), 32'd0);
                end
                if (bus.rx_valid) begin
                    n_rxv++;
                    check("rx_valid_width", 32'(p_rxv), 32'd0);
                end
                if (bus.stop_det) begin
                    n_stop++;
                    check("stop_det_width", 32'(p_stop), 32'd0);
                end
                if (bus.tx_req) begin
                    n_txr++;
                    check("tx_req_width", 32'(p_txr), 32'd0);
                    if (tx_q.size() > 0) bus.tx_data = tx_q.pop_front();
                    else bus.tx_data = 8'hEE;
                end
                if (bus.sda_oe !== p_oe) check("oe_change_scl_low", 32'(bus.scl_in), 32'd0);
                if (!oe_allowed) check("oe_released", 32'(bus.sda_oe), 32'd0);
            end
            p_am = bus.addr_match; p_rxv = bus.rx_valid;
            p_txr = bus.tx_req; p_stop = bus.stop_det; p_oe = bus.sda_oe;
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        #Q; scl_m = 1'b1;
        #Q; s = bus.sda_in;
        #Q; scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        oe_allowed = 1'b0;
        e_addressed = 1'b0;
        sda_m = 1'b1;
        #Q; scl_m = 1'b1;
        #Q; sda_m = 1'b0;
        #Q; scl_m = 1'b0;
        #Q;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic i2c_stop();
        oe_allowed = 1'b0;
        sda_m = 1'b0;
        #Q; scl_m = 1'b1;
        #Q; sda_m = 1'b1;
        #Q;
        e_stop++;
        e_addressed = 1'b0;
        check("busy_after_stop", 32'(bus.busy), 32'd0);
        check("oe_after_stop", 32'(bus.sda_oe), 32'd0);
    endtask

    task automatic addr_byte(input logic [7:0] a);
        logic s;
        logic match;
        match = (a[7:1] == OWN);
        if (match) oe_allowed = 1'b1;
        for (int i = 7; i >= 0; i--) clock_bit(a[i], s);
        clock_bit(1'b1, s);
        check("addr_ack", 32'(s), match ? 32'd0 : 32'd1);
        if (match) begin
            e_am++;
            e_rw = a[0];
            e_addressed = 1'b1;
            if (a[0]) e_txr++;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic s;
        logic acked;
        acked = e_addressed && !e_rw;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        check("write_ack", 32'(s), acked ? 32'd0 : 32'd1);
        if (acked) begin
            e_rxv++;
            e_rx = b;
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] got);
        logic s;
        logic [7:0] expb;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            got = {got[6:0], s};
        end
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
        check("read_byte_model", 32'(got), 32'(expb));
        if (nack) begin
            oe_allowed = 1'b0;
            e_addressed = 1'b0;
        end else begin
            e_txr++;
        end
        clock_bit(nack, s);
    endtask

    task automatic compare_model();
        check("cnt_addr_match", n_am, e_am);
        check("cnt_rx_valid", n_rxv, e_rxv);
        check("cnt_tx_req", n_txr, e_txr);
        check("cnt_stop_det", n_stop, e_stop);
        check("rx_data", 32'(bus.rx_data), 32'(e_rx));
        check("rw_at_match", 32'(last_rw), 32'(e_rw));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oe"}, 32'(bus.sda_oe), 32'd0);
        check({tag, "_addr_match"}, 32'(bus.addr_match), 32'd0);
        check({tag, "_rw"}, 32'(bus.rw), 32'd0);
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        check({tag, "_tx_req"}, 32'(bus.tx_req), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_stop_det"}, 32'(bus.stop_det), 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        logic       s;
        int         txr0;

        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write 0x50+W, 0xA5
        i2c_start();
        addr_byte(8'hA0);
        write_byte(8'hA5);
        i2c_stop();
        compare_model();
        check("wr_rx_data_lit", 32'(bus.rx_data), 32'hA5);
        check("wr_addr_match_lit", n_am, 1);

        // Foreign address 0x51+W, 0xFF
        i2c_start();
        addr_byte(8'hA2);
        write_byte(8'hFF);
        i2c_stop();
        compare_model();

        // General call is not ours
        i2c_start();
        addr_byte(8'h00);
        write_byte(8'h12);
        i2c_stop();
        compare_model();

        // Read 0x50+R: 0x3C (ACK) then 0xC3 (NACK)
        txr0 = n_txr;
        tx_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        tx_q.push_back(8'hC3); exp_q.push_back(8'hC3);
        i2c_start();
        addr_byte(8'hA1);
        read_byte(1'b0, got);
        check("rd_byte0_lit", 32'(got), 32'h3C);
        read_byte(1'b1, got);
        check("rd_byte1_lit", 32'(got), 32'hC3);
        i2c_stop();
        compare_model();
        check("rd_tx_req_lit", n_txr - txr0, 2);

        // Write 0x11, repeated START, read one byte
        tx_q.push_back(8'h96); exp_q.push_back(8'h96);
        i2c_start();
        addr_byte(8'hA0);
        write_byte(8'h11);
        i2c_start();
        addr_byte(8'hA1);
        check("rs_rw_lit", 32'(last_rw), 32'd1);
        read_byte(1'b1, got);
        i2c_stop();
        compare_model();
        check("rs_rx_data_lit", 32'(bus.rx_data), 32'h11);

        // STOP after 4 bits of a write byte, then a full transfer
        i2c_start();
        addr_byte(8'hA0);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        i2c_stop();
        compare_model();
        i2c_start();
        addr_byte(8'hA0);
        write_byte(8'h77);
        i2c_stop();
        compare_model();

        // Reset while ACKing a write byte
        i2c_start();
        addr_byte(8'hA0);
        for (int i = 7; i >= 0; i--) clock_bit(1'(8'h3C >> i), s);
        e_rxv++;
        check("oe_in_wr_ack", 32'(bus.sda_oe), 32'd1);
        @(posedge clk);
        #20 rst_n = 1'b0;
        oe_allowed = 1'b0;
        e_addressed = 1'b0;
        e_rx = 8'h00;
        #1;
        check("oe_async_reset", 32'(bus.sda_oe), 32'd0);
        check_reset_outputs("midreset");
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #Q;
        compare_model();
        i2c_start();
        addr_byte(8'hA0);
        write_byte(8'h5A);
        i2c_stop();
        compare_model();
        check("post_reset_rx_lit", 32'(bus.rx_data), 32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
